// File: rtl/max_scan_if.sv
// Handshake and result bundle between the score registers and the max_scan winner finder.
// The master drives the scan request and channel data; the slave returns busy/done and the result.
interface max_scan_if #(
  parameter int N = 4,
  parameter int W = 7
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic            start;
  logic [N*W-1:0]  bus_in;
  logic [N-1:0]    en_mask;
  logic            busy;
  logic            done;
  logic [N-1:0]    winner;
  logic [IW-1:0]   winner_idx;
  logic [W-1:0]    max_val;
  logic            tie;
  logic            none;

  modport master (
    output start, bus_in, en_mask,
    input  busy, done, winner, winner_idx, max_val, tie, none
  );

  modport slave (
    input  start, bus_in, en_mask,
    output busy, done, winner, winner_idx, max_val, tie, none
  );
endinterface

// File: rtl/max_scan.sv
// Sequential winner finder: snapshots N channels on start, scans one channel per clock,
// and publishes max value, winning channel, tie and no-candidate flags on a done pulse.
module max_scan #(
  parameter int N = 4,
  parameter int W = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  max_scan_if.slave  bus
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t          state_q, state_d;
  logic [N*W-1:0]  snapVal_q, snapVal_d;
  logic [N-1:0]    snapMask_q, snapMask_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [W-1:0]    maxW_q, maxW_d;
  logic [IW-1:0]   win_q, win_d;
  logic [1:0]      cnt_q, cnt_d;
  logic            found_q, found_d;

  logic [W-1:0]    maxVal_q, maxVal_d;
  logic [IW-1:0]   winnerIdx_q, winnerIdx_d;
  logic [N-1:0]    winner_q, winner_d;
  logic            tie_q, tie_d;
  logic            none_q, none_d;

  logic [W-1:0]    chVal;
  logic            chEn;

  always_comb begin
    state_d     = state_q;
    snapVal_d   = snapVal_q;
    snapMask_d  = snapMask_q;
    idx_d       = idx_q;
    maxW_d      = maxW_q;
    win_d       = win_q;
    cnt_d       = cnt_q;
    found_d     = found_q;
    maxVal_d    = maxVal_q;
    winnerIdx_d = winnerIdx_q;
    winner_d    = winner_q;
    tie_d       = tie_q;
    none_d      = none_q;
    chVal       = snapVal_q[idx_q*W +: W];
    chEn        = snapMask_q[idx_q];

    case (state_q)
      IDLE: begin
        if (bus.start) state_d = SCAN;
      end
      SCAN: begin
        if (chEn) begin
          if (!found_q || (chVal > maxW_q)) begin
            maxW_d  = chVal;
            win_d   = idx_q;
            cnt_d   = 2'd1;
            found_d = 1'b1;
          end else if (chVal == maxW_q) begin
            win_d = idx_q;
            cnt_d = (cnt_q == 2'd2) ? 2'd2 : cnt_q + 2'd1;
          end
        end
        // Results load on the final scan edge so they are already valid while done is high.
        if (idx_q == IW'(N-1)) begin
          state_d = DONE;
          if (found_d) begin
            maxVal_d    = maxW_d;
            winnerIdx_d = win_d;
            winner_d    = {{(N-1){1'b0}}, 1'b1} << win_d;
            tie_d       = (cnt_d >= 2'd2);
            none_d      = 1'b0;
          end else begin
            maxVal_d    = '0;
            winnerIdx_d = '0;
            winner_d    = '0;
            tie_d       = 1'b0;
            none_d      = 1'b1;
          end
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        state_d = bus.start ? SCAN : IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A new snapshot is taken from IDLE or straight out of DONE; start during SCAN is dropped.
    if ((state_q != SCAN) && bus.start) begin
      snapVal_d  = bus.bus_in;
      snapMask_d = bus.en_mask;
      idx_d      = '0;
      maxW_d     = '0;
      win_d      = '0;
      cnt_d      = 2'd0;
      found_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      snapVal_q   <= '0;
      snapMask_q  <= '0;
      idx_q       <= '0;
      maxW_q      <= '0;
      win_q       <= '0;
      cnt_q       <= 2'd0;
      found_q     <= 1'b0;
      maxVal_q    <= '0;
      winnerIdx_q <= '0;
      winner_q    <= '0;
      tie_q       <= 1'b0;
      none_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      snapVal_q   <= snapVal_d;
      snapMask_q  <= snapMask_d;
      idx_q       <= idx_d;
      maxW_q      <= maxW_d;
      win_q       <= win_d;
      cnt_q       <= cnt_d;
      found_q     <= found_d;
      maxVal_q    <= maxVal_d;
      winnerIdx_q <= winnerIdx_d;
      winner_q    <= winner_d;
      tie_q       <= tie_d;
      none_q      <= none_d;
    end
  end

  assign bus.busy       = (state_q != IDLE);
  assign bus.done       = (state_q == DONE);
  assign bus.winner     = winner_q;
  assign bus.winner_idx = winnerIdx_q;
  assign bus.max_val    = maxVal_q;
  assign bus.tie        = tie_q;
  assign bus.none       = none_q;
endmodule

// File: tb/tb_max_scan.sv
// Self-checking bench for max_scan: directed cases from the test plan plus random scans
// compared against a simple "max over enabled channels" reference model.
module tb_max_scan;
  localparam int N  = 4;
  localparam int W  = 7;
  localparam int IW = 2;

  typedef struct packed {
    logic [W-1:0]  maxVal;
    logic [IW-1:0] idx;
    logic [N-1:0]  onehot;
    logic          tie;
    logic          none;
  } result_t;

  logic clk;
  logic rst_n;
  int   assertCount = 0;
  int   failCount   = 0;

  logic [W-1:0] chVals [N];
  logic [N-1:0] chMask;

  max_scan_if #(.N(N), .W(W)) sif ();

  max_scan #(.N(N), .W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference: largest enabled value, highest index holding it, tie when two or more hold it.
  function automatic result_t refModel();
    result_t r;
    int best = -1;
    int hits = 0;
    int winIdx = 0;
    for (int i = 0; i < N; i++)
      if (chMask[i] && (int'(chVals[i]) > best)) best = int'(chVals[i]);
    for (int i = 0; i < N; i++)
      if (chMask[i] && (int'(chVals[i]) == best)) begin
        hits++;
        winIdx = i;
      end
    r = '0;
    if (best < 0) begin
      r.none = 1'b1;
    end else begin
      r.maxVal = W'(best);
      r.idx    = IW'(winIdx);
      r.onehot = N'(1) << winIdx;
      r.tie    = (hits >= 2);
    end
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int v0, input int v1, input int v2, input int v3,
                               input logic [N-1:0] m);
    @(negedge clk);
    chVals[0] = W'(v0);
    chVals[1] = W'(v1);
    chVals[2] = W'(v2);
    chVals[3] = W'(v3);
    chMask    = m;
    for (int i = 0; i < N; i++) sif.bus_in[i*W +: W] = chVals[i];
    sif.en_mask = chMask;
  endtask

  task automatic startScan();
    @(negedge clk);
    sif.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sif.start = 1'b0;
  endtask

  task automatic waitDone(output int cycles);
    cycles = -1;
    for (int k = 1; k <= 3 * N + 4; k++) begin
      @(posedge clk);
      #1;
      if (sif.done === 1'b1) begin
        cycles = k;
        break;
      end
    end
  endtask

  task automatic checkResult(input string tag, input result_t exp);
    checkOutput({tag, " done"},       32'(sif.done),       32'd1);
    checkOutput({tag, " busy"},       32'(sif.busy),       32'd1);
    checkOutput({tag, " max_val"},    32'(sif.max_val),    32'(exp.maxVal));
    checkOutput({tag, " winner_idx"}, 32'(sif.winner_idx), 32'(exp.idx));
    checkOutput({tag, " winner"},     32'(sif.winner),     32'(exp.onehot));
    checkOutput({tag, " tie"},        32'(sif.tie),        32'(exp.tie));
    checkOutput({tag, " none"},       32'(sif.none),       32'(exp.none));
  endtask

  task automatic runAndCheck(input string tag);
    result_t exp;
    int c;
    exp = refModel();
    startScan();
    waitDone(c);
    checkOutput({tag, " latency"}, 32'(c), 32'(N));
    checkResult(tag, exp);
    @(posedge clk);
    #1;
    checkOutput({tag, " done pulse"}, 32'(sif.done), 32'd0);
    checkOutput({tag, " idle busy"},  32'(sif.busy), 32'd0);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " busy"},       32'(sif.busy),       32'd0);
    checkOutput({tag, " done"},       32'(sif.done),       32'd0);
    checkOutput({tag, " winner"},     32'(sif.winner),     32'd0);
    checkOutput({tag, " winner_idx"}, 32'(sif.winner_idx), 32'd0);
    checkOutput({tag, " max_val"},    32'(sif.max_val),    32'd0);
    checkOutput({tag, " tie"},        32'(sif.tie),        32'd0);
    checkOutput({tag, " none"},       32'(sif.none),       32'd0);
  endtask

  initial begin
    result_t exp;
    result_t exp2;
    int c;
    int extra;

    rst_n       = 1'b0;
    sif.start   = 1'b1;
    sif.bus_in  = '0;
    sif.en_mask = '1;
    for (int i = 0; i < N; i++) chVals[i] = '0;
    chMask = '1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n     = 1'b1;
    sif.start = 1'b0;
    checkAllZero("reset");
    @(posedge clk);
    #1;
    checkOutput("reset idle busy", 32'(sif.busy), 32'd0);

    applyStimulus(10, 20, 5, 7, 4'b1111);
    runAndCheck("distinct");
    applyStimulus(50, 50, 50, 3, 4'b1111);
    runAndCheck("tie50");
    applyStimulus(0, 0, 0, 0, 4'b1111);
    runAndCheck("allzero");
    applyStimulus(127, 127, 127, 127, 4'b1111);
    runAndCheck("allmax");
    applyStimulus(1, 2, 3, 127, 4'b0111);
    runAndCheck("mask0111");
    applyStimulus(1, 2, 3, 127, 4'b0000);
    runAndCheck("mask0000");
    applyStimulus(1, 2, 3, 127, 4'b1000);
    runAndCheck("mask1000");

    // Live bus change after the snapshot must not affect the result.
    applyStimulus(10, 20, 5, 7, 4'b1111);
    exp = refModel();
    startScan();
    sif.bus_in[0 +: W] = W'(99);
    waitDone(c);
    checkOutput("snapshot latency", 32'(c), 32'(N));
    checkResult("snapshot", exp);

    // A start pulse mid-scan is ignored and yields no second done.
    applyStimulus(33, 60, 60, 12, 4'b1111);
    exp = refModel();
    startScan();
    @(negedge clk);
    sif.start = 1'b1;
    @(negedge clk);
    sif.start = 1'b0;
    waitDone(c);
    checkOutput("midstart found done", 32'(c > 0), 32'd1);
    checkResult("midstart", exp);
    extra = 0;
    for (int k = 0; k < 2 * N; k++) begin
      @(posedge clk);
      #1;
      if (sif.done === 1'b1) extra++;
    end
    checkOutput("midstart extra done", 32'(extra), 32'd0);

    // Start held through DONE chains a second scan with no idle gap.
    applyStimulus(4, 90, 17, 2, 4'b1101);
    exp = refModel();
    @(negedge clk);
    sif.start = 1'b1;
    waitDone(c);
    checkOutput("b2b first latency", 32'(c), 32'(N + 1));
    checkResult("b2b first", exp);
    applyStimulus(70, 8, 70, 70, 4'b0101);
    exp2 = refModel();
    waitDone(c);
    checkOutput("b2b interval", 32'(c), 32'(N + 1));
    checkResult("b2b second", exp2);
    @(negedge clk);
    sif.start = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("b2b back to idle", 32'(sif.busy), 32'd0);

    // Reset in the middle of a scan aborts it silently and clears the outputs.
    applyStimulus(5, 100, 100, 9, 4'b1111);
    runAndCheck("prereset");
    startScan();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    checkAllZero("midreset");
    extra = 0;
    for (int k = 0; k < N + 2; k++) begin
      @(posedge clk);
      #1;
      if (sif.done === 1'b1) extra++;
    end
    checkOutput("midreset no done", 32'(extra), 32'd0);
    applyStimulus(11, 22, 33, 44, 4'b1111);
    runAndCheck("postreset");

    for (int t = 0; t < 24; t++) begin
      if (t % 2 == 0)
        applyStimulus($urandom_range(0, 127), $urandom_range(0, 127),
                      $urandom_range(0, 127), $urandom_range(0, 127), N'($urandom));
      else
        applyStimulus($urandom_range(0, 3), $urandom_range(0, 3),
                      $urandom_range(0, 3), $urandom_range(0, 3), N'($urandom));
      runAndCheck($sformatf("random%0d", t));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end
endmodule
